// File: rtl/percept_seq.sv
// percept_seq
//   Serial sequencer in front of the perceptron serial multiply-accumulate
//   datapath. Accepts (data, weight) pairs, shifts them into the datapath,
//   issues MUL for the first pair of a dot product and MUL_ADD for the rest,
//   then reads the 4*SIZE-bit accumulator back serially after the last pair.
//
// Ports
//   clk        rising-edge clock, shared with the datapath
//   rst        asynchronous active-high reset
//   in_valid   input pair valid
//   in_ready   sequencer accepts a pair this cycle (registered)
//   in_x       data operand, unsigned
//   in_w       weight operand, unsigned
//   in_last    pair closes the dot product; triggers readout
//   opcode     registered 3-bit opcode to the datapath
//   rx         registered serial bit to the datapath
//   tx         serial bit from the datapath (accumulator MSB during OUT_RES)
//   res_valid  res_data holds a completed dot product (registered)
//   res_ready  consumer accepts the result
//   res_data   dot-product result, mod 2^(4*SIZE)

module percept_seq #(
  parameter int SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE-1:0]     in_x,
  input  logic [SIZE-1:0]     in_w,
  input  logic                in_last,
  output logic [2:0]          opcode,
  output logic                rx,
  input  logic                tx,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*SIZE-1:0]   res_data
);

  localparam int CNT_W = $clog2(4 * SIZE);
  localparam logic [CNT_W-1:0] LOAD_END = CNT_W'(2 * SIZE - 1);
  localparam logic [CNT_W-1:0] READ_END = CNT_W'(4 * SIZE - 1);

  // Datapath opcode encoding. OUT_DATA1, OUT_DATA2 and LOAD_RES exist in the
  // datapath but are never issued by this sequencer.
  typedef enum logic [2:0] {
    OP_OUT_DATA1 = 3'd0,
    OP_OUT_DATA2 = 3'd1,
    OP_OUT_RES   = 3'd2,
    OP_LOAD      = 3'd3,
    OP_LOAD_RES  = 3'd4,
    OP_MUL       = 3'd5,
    OP_MUL_ADD   = 3'd6,
    OP_NO_OP     = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_READ,
    S_DONE
  } state_e;

  state_e                state;
  logic [2*SIZE-1:0]     shift_reg;   // {w, x}, shifted out MSB-first
  logic                  last_q;
  logic                  first;       // next MAC starts a new dot product
  logic [CNT_W-1:0]      cnt;

  // All outputs are computed one cycle ahead so they leave the block straight
  // from flops; tx is only consumed while the registered opcode is OUT_RES,
  // which keeps the loop through the datapath broken by a register.
  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      last_q    <= 1'b0;
      first     <= 1'b1;
      cnt       <= '0;
      opcode    <= OP_NO_OP;
      rx        <= 1'b0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is a transfer.
          if (in_valid) begin
            shift_reg <= {in_w, in_x};
            last_q    <= in_last;
            cnt       <= '0;
            rx        <= in_w[SIZE-1];
            opcode    <= OP_LOAD;
            in_ready  <= 1'b0;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          // rx for the next cycle is the bit that becomes the MSB after this shift.
          shift_reg <= shift_reg << 1;
          rx        <= shift_reg[2*SIZE-2];
          cnt       <= cnt + 1'b1;
          if (cnt == LOAD_END) begin
            cnt    <= '0;
            rx     <= 1'b0;
            opcode <= first ? OP_MUL : OP_MUL_ADD;
            state  <= S_MAC;
          end
        end

        S_MAC: begin
          // Clearing first and re-arming it on the last pair collapse to this.
          first <= last_q;
          if (last_q) begin
            cnt    <= '0;
            opcode <= OP_OUT_RES;
            state  <= S_READ;
          end else begin
            opcode   <= OP_NO_OP;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end

        S_READ: begin
          // The full 4*SIZE shifts overwrite whatever res_data held before.
          res_data <= {res_data[4*SIZE-2:0], tx};
          cnt      <= cnt + 1'b1;
          if (cnt == READ_END) begin
            cnt       <= '0;
            opcode    <= OP_NO_OP;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state    <= S_IDLE;
          opcode   <= OP_NO_OP;
          rx       <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_percept_seq.sv
// tb_percept_seq
//   Self-checking bench for percept_seq. Contains a behavioural model of the
//   serial MAC datapath (driven by opcode/rx, returning tx) and a scoreboard:
//   expected dot products are pushed when the last pair is accepted and
//   popped when the result handshake completes.

module tb_percept_seq;

  localparam int S = 32;
  localparam int W = 4 * S;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [S-1:0]     in_x;
  logic [S-1:0]     in_w;
  logic             in_last;
  logic [2:0]       opcode;
  logic             rx;
  logic             tx;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_data;

  always #5 clk = ~clk;

  percept_seq #(.SIZE(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_last   (in_last),
    .opcode    (opcode),
    .rx        (rx),
    .tx        (tx),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- datapath model (not reset: it keeps partial state) -----
  logic [2*S-1:0] dp_ops = '0;   // {data_2, data_1}
  logic [W-1:0]   dp_acc = '0;

  always @(posedge clk) begin
    case (opcode)
      3'd3: dp_ops <= {dp_ops[2*S-2:0], rx};
      3'd5: dp_acc <= W'(dp_ops[2*S-1:S]) * W'(dp_ops[S-1:0]);
      3'd6: dp_acc <= dp_acc + W'(dp_ops[2*S-1:S]) * W'(dp_ops[S-1:0]);
      3'd2: dp_acc <= {dp_acc[W-2:0], 1'b0};
      default: ;
    endcase
  end
  assign tx = dp_acc[W-1];

  // ---------------- monitor + scoreboard -----------------------------------
  int           cyc = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] sum_model   = '0;
  logic [W-1:0] prod;
  logic [W-1:0] last_popped = '0;
  bit           first_model = 1'b1;
  bit           prev_valid  = 1'b0;
  int           load_cnt = 0, mul_cnt = 0, mul_add_cnt = 0, out_cnt = 0, bad_op_cnt = 0;
  int           t_acc_last = 0, t_valid = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      sum_model   = '0;
      first_model = 1'b1;
      prev_valid  = 1'b0;
    end else begin
      case (opcode)
        3'd3: load_cnt++;
        3'd5: mul_cnt++;
        3'd6: mul_add_cnt++;
        3'd2: out_cnt++;
        3'd0, 3'd1, 3'd4: bad_op_cnt++;
        default: ;
      endcase
      if (in_valid && in_ready) begin
        prod        = W'(in_x) * W'(in_w);
        sum_model   = first_model ? prod : sum_model + prod;
        first_model = 1'b0;
        if (in_last) begin
          sb.push_back(sum_model);
          first_model = 1'b1;
          t_acc_last  = cyc;
        end
      end
      if (res_valid && !prev_valid) t_valid = cyc;
      prev_valid = res_valid;
      if (res_valid && res_ready) begin
        check("sb_nonempty", W'(sb.size() > 0), W'(1));
        if (sb.size() > 0) begin
          last_popped = sb.pop_front();
          check("res_data", res_data, last_popped);
        end
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic send(input logic [S-1:0] x, input logic [S-1:0] w, input logic last);
    bit ok = 1'b0;
    in_x     = x;
    in_w     = w;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_in_time", W'(ok), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_in_time", W'(ok), W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    load_cnt    = 0;
    mul_cnt     = 0;
    mul_add_cnt = 0;
    out_cnt     = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_opcode"},    W'(opcode),    W'(7));
    check({tag, "_rx"},        W'(rx),        W'(0));
    check({tag, "_in_ready"},  W'(in_ready),  W'(1));
    check({tag, "_res_valid"}, W'(res_valid), W'(0));
    check({tag, "_res_data"},  res_data,      W'(0));
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_w      = '0;
    in_last   = 1'b0;
    res_ready = 1'b1;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single pair: exact phase lengths and result latency.
    clear_counts();
    send(32'd3, 32'd5, 1'b1);
    drain();
    check("t1_load_cycles", W'(load_cnt), W'(64));
    check("t1_mul",         W'(mul_cnt),  W'(1));
    check("t1_mul_add",     W'(mul_add_cnt), W'(0));
    check("t1_out_cycles",  W'(out_cnt),  W'(128));
    check("t1_latency",     W'(t_valid - t_acc_last), W'(194));
    check("t1_value",       last_popped,  W'(15));

    // Three-pair dot product, then a fresh one.
    clear_counts();
    send(32'd7, 32'd2, 1'b0);
    send(32'd4, 32'd3, 1'b0);
    send(32'd10, 32'd10, 1'b1);
    drain();
    check("t2_mul",     W'(mul_cnt),     W'(1));
    check("t2_mul_add", W'(mul_add_cnt), W'(2));
    check("t2_value",   last_popped,     W'(126));
    clear_counts();
    send(32'd1, 32'd1, 1'b1);
    drain();
    check("t2b_mul",     W'(mul_cnt),     W'(1));
    check("t2b_mul_add", W'(mul_add_cnt), W'(0));
    check("t2b_value",   last_popped,     W'(1));

    // Max operands.
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drain();
    check("t3_max1", last_popped, W'(64'hFFFF_FFFE_0000_0001));
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drain();
    check("t3_max2", last_popped, W'(68'h1_FFFF_FFFC_0000_0002));

    // Result back-pressure.
    res_ready = 1'b0;
    send(32'd2, 32'd3, 1'b1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (res_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("t4_valid_seen", W'(seen), W'(1));
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("t4_hold_data",     res_data,       W'(6));
      check("t4_hold_in_ready", W'(in_ready),   W'(0));
      check("t4_hold_opcode",   W'(opcode),     W'(7));
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_released", W'(res_valid), W'(0));
    check("t4_sb_empty", W'(sb.size()), W'(0));
    check("t4_value",    last_popped,   W'(6));

    // Reset during LOAD, then a clean dot product.
    send(32'd9, 32'd9, 1'b0);
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("midrst_hold");
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_counts();
    send(32'd6, 32'd7, 1'b1);
    drain();
    check("t5_mul",     W'(mul_cnt),     W'(1));
    check("t5_mul_add", W'(mul_add_cnt), W'(0));
    check("t5_value",   last_popped,     W'(42));

    // Random pairs with random input gaps against the software model.
    for (int d = 0; d < 10; d++) begin
      for (int p = 0; p < 10; p++) begin
        int gap = $urandom_range(0, 3);
        repeat (gap) @(posedge clk);
        #1;
        send(32'($urandom), 32'($urandom), 1'(p == 9));
      end
    end
    drain();

    check("opcode_legal", W'(bad_op_cnt), W'(0));
    check("sb_final",     W'(sb.size()),  W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
